// File: rtl/tea_pkg.sv
// Shared definitions for the TEA cipher core.
//   DELTA_DEFAULT : key-schedule constant used when DELTA is not overridden
//   word_t        : 32-bit TEA word
//   state_t       : control states IDLE / RUN / DONE
//   dec_sum_init  : starting sum for decryption, DELTA*ROUNDS mod 2^32
package tea_pkg;

  localparam logic [31:0] DELTA_DEFAULT = 32'h9E3779B9;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic word_t dec_sum_init(input word_t delta, input int unsigned rounds);
    logic [63:0] prod;
    prod = {32'd0, delta} * {32'd0, 32'(rounds)};
    return prod[31:0];
  endfunction

endpackage

// File: rtl/tea_round_f.sv
// TEA mixing function F(x,ka,kb,s) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb).
// Purely combinational; all arithmetic wraps mod 2^32.
// Ports:
//   x  : word being mixed
//   ka : key word added to the left-shifted term
//   kb : key word added to the right-shifted term
//   s  : current round sum
//   f  : mixed result
module tea_round_f
  import tea_pkg::*;
(
  input  word_t x,
  input  word_t ka,
  input  word_t kb,
  input  word_t s,
  output word_t f
);

  assign f = ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);

endmodule

// File: rtl/tea_cipher_core.sv
// Iterative TEA block cipher, one TEA cycle (two Feistel half-rounds) per clock.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   start    : begin a block; sampled only in IDLE
//   mode     : 0 = encrypt, 1 = decrypt; sampled with start
//   key      : 128-bit key {k0,k1,k2,k3}; sampled with start
//   data_in  : 64-bit block {v0,v1}; sampled with start
//   busy     : high whenever the core is not IDLE
//   done     : one-clock completion pulse
//   data_out : result {v0,v1}; valid with done, held until the next completion
module tea_cipher_core
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = 32,
  parameter word_t       DELTA  = DELTA_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [127:0]  key,
  input  logic [63:0]   data_in,
  output logic          busy,
  output logic          done,
  output logic [63:0]   data_out
);

  localparam int unsigned     CW      = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0]   LAST    = CW'(ROUNDS - 1);
  localparam word_t           SUM_DEC = dec_sum_init(DELTA, ROUNDS);

  state_t          state;
  state_t          state_next;

  word_t           v0;
  word_t           v1;
  word_t           sum;
  logic [127:0]    key_q;
  logic            dec;
  logic [CW-1:0]   cnt;
  logic            last_round;

  word_t           k0, k1, k2, k3;
  word_t           s_enc;
  word_t           fa_x, fa_ka, fa_kb, f_s, f_a;
  word_t           mid;
  word_t           fb_ka, fb_kb, f_b;
  word_t           fin;
  word_t           v0_next;
  word_t           v1_next;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  assign last_round = (cnt == LAST);

  // Both directions share the two F instances. Encrypt updates v0 first
  // then v1 with the pre-incremented sum; decrypt updates v1 first then v0
  // with the current sum. The first instance's result ("mid") is the word
  // updated first, and feeds the second instance.
  assign s_enc = sum + DELTA;
  assign f_s   = dec ? sum : s_enc;
  assign fa_x  = dec ? v0  : v1;
  assign fa_ka = dec ? k2  : k0;
  assign fa_kb = dec ? k3  : k1;
  assign fb_ka = dec ? k0  : k2;
  assign fb_kb = dec ? k1  : k3;

  tea_round_f u_f_a (
    .x  (fa_x),
    .ka (fa_ka),
    .kb (fa_kb),
    .s  (f_s),
    .f  (f_a)
  );

  assign mid = dec ? (v1 - f_a) : (v0 + f_a);

  tea_round_f u_f_b (
    .x  (mid),
    .ka (fb_ka),
    .kb (fb_kb),
    .s  (f_s),
    .f  (f_b)
  );

  assign fin     = dec ? (v0 - f_b) : (v1 + f_b);
  assign v0_next = dec ? fin : mid;
  assign v1_next = dec ? mid : fin;

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_round) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      v0       <= '0;
      v1       <= '0;
      sum      <= '0;
      key_q    <= '0;
      dec      <= 1'b0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            v0    <= data_in[63:32];
            v1    <= data_in[31:0];
            key_q <= key;
            dec   <= mode;
            cnt   <= '0;
            sum   <= mode ? SUM_DEC : '0;
          end
        end
        RUN: begin
          v0  <= v0_next;
          v1  <= v1_next;
          sum <= dec ? (sum - DELTA) : s_enc;
          cnt <= cnt + 1'b1;
          if (last_round) begin
            data_out <= {v0_next, v1_next};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_cipher_core.sv
// Scoreboard bench for tea_cipher_core: two instances (ROUNDS=32 and 16).
// Stimulus pushes expected results (from a plain TEA reference model) with the
// accept cycle; a monitor pops on every done pulse and checks data and latency.
module tb_tea_cipher_core;

  localparam logic [31:0] TB_DELTA = 32'h9E3779B9;

  typedef struct {
    logic [63:0] exp;
    int          acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start    [2];
  logic         mode     [2];
  logic [127:0] key      [2];
  logic [63:0]  din      [2];
  logic [63:0]  dout     [2];
  logic         busy     [2];
  logic         done     [2];
  logic         prev_done[2];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tea_cipher_core #(.ROUNDS(32), .DELTA(32'h9E3779B9)) dut32 (
    .clk(clk), .reset(reset), .start(start[0]), .mode(mode[0]), .key(key[0]),
    .data_in(din[0]), .busy(busy[0]), .done(done[0]), .data_out(dout[0])
  );

  tea_cipher_core #(.ROUNDS(16), .DELTA(32'h9E3779B9)) dut16 (
    .clk(clk), .reset(reset), .start(start[1]), .mode(mode[1]), .key(key[1]),
    .data_in(din[1]), .busy(busy[1]), .done(done[1]), .data_out(dout[1])
  );

  function automatic int rnds(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  // Textbook TEA, written from the cipher definition.
  function automatic logic [63:0] tea_ref(input logic m, input logic [127:0] k,
                                          input logic [63:0] d, input int rounds);
    logic [31:0] y, z, s, a, b, c, e;
    y = d[63:32]; z = d[31:0];
    a = k[127:96]; b = k[95:64]; c = k[63:32]; e = k[31:0];
    if (!m) begin
      s = 0;
      for (int i = 0; i < rounds; i++) begin
        s = s + TB_DELTA;
        y = y + (((z << 4) + a) ^ (z + s) ^ ((z >> 5) + b));
        z = z + (((y << 4) + c) ^ (y + s) ^ ((y >> 5) + e));
      end
    end else begin
      s = TB_DELTA * rounds;
      for (int i = 0; i < rounds; i++) begin
        z = z - (((y << 4) + c) ^ (y + s) ^ ((y >> 5) + e));
        y = y - (((z << 4) + a) ^ (z + s) ^ ((z >> 5) + b));
        s = s - TB_DELTA;
      end
    end
    return {y, z};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_exp(input int d, input logic [63:0] e, input int a);
    exp_t x;
    x.exp = e; x.acc = a;
    if (d == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic pop_exp(input int d, output exp_t x);
    if (d == 0) x = q0.pop_front(); else x = q1.pop_front();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    prev_done[0] = 1'b0;
    prev_done[1] = 1'b0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d] === 1'b1) begin
        chk($sformatf("done_single_pulse[%0d]", d), {63'd0, prev_done[d]}, 64'd0);
        if (qsize(d) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done[%0d]: done=1 with no block outstanding (t=%0t)", d, $time);
        end else begin
          exp_t x;
          pop_exp(d, x);
          chk($sformatf("data_out[%0d]", d), dout[d], x.exp);
          // done is sampled high at the (ROUNDS+1)-th edge after the accept edge
          chk($sformatf("done_latency[%0d]", d), 64'(cyc + 1 - x.acc), 64'(rnds(d) + 1));
        end
      end
      prev_done[d] = done[d];
    end
  end

  task automatic check_idle(input int d, input string tag);
    chk({tag, "_busy"}, {63'd0, busy[d]}, 64'd0);
    chk({tag, "_done"}, {63'd0, done[d]}, 64'd0);
    chk({tag, "_data_out"}, dout[d], 64'd0);
  endtask

  task automatic wait_idle(input int d);
    int budget;
    budget = 200;
    @(negedge clk);
    while (busy[d] !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL idle_timeout[%0d]: busy=%b required 0", d, busy[d]);
    end
  endtask

  // Present one block for one clock; core must be idle.
  task automatic issue(input int d, input logic m, input logic [127:0] k,
                       input logic [63:0] data, input bit push, output int acc);
    mode[d] = m; key[d] = k; din[d] = data; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    acc = cyc;
    chk($sformatf("accept_busy[%0d]", d), {63'd0, busy[d]}, 64'd1);
    if (push) push_exp(d, tea_ref(m, k, data, rnds(d)), acc);
  endtask

  task automatic prep(input int d, input int j, inout logic [63:0] p,
                      inout logic [127:0] k, inout logic [63:0] c, output logic [63:0] e);
    if (j % 2 == 0) begin
      p = rand64(); k = rand128();
      c = tea_ref(1'b0, k, p, rnds(d));
      mode[d] = 1'b0; key[d] = k; din[d] = p; e = c;
    end else begin
      mode[d] = 1'b1; key[d] = k; din[d] = c; e = p;
    end
  endtask

  // Start held high: alternating encrypt / decrypt-of-ciphertext blocks.
  task automatic run_pairs(input int d, input int n);
    logic [63:0]  p, c, e;
    logic [127:0] k;
    int j, last_acc, idle_cnt, budget;
    logic prev_busy;
    p = '0; c = '0; k = '0;
    j = 0; last_acc = -1; idle_cnt = 0;
    budget = (n + 2) * (rnds(d) + 2) + 20;
    @(negedge clk);
    prep(d, j, p, k, c, e);
    start[d] = 1'b1;
    prev_busy = busy[d];
    while (j < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (busy[d] && !prev_busy) begin
        push_exp(d, e, cyc);
        if (last_acc >= 0) begin
          chk($sformatf("throughput[%0d]", d), 64'(cyc - last_acc), 64'(rnds(d) + 2));
          chk($sformatf("idle_gap[%0d]", d), 64'(idle_cnt), 64'd1);
        end
        last_acc = cyc; idle_cnt = 0; j++;
        if (j < n) prep(d, j, p, k, c, e);
        else start[d] = 1'b0;
      end else if (!busy[d]) begin
        idle_cnt++;
      end
      prev_busy = busy[d];
    end
    if (j < n) begin
      start[d] = 1'b0;
      checks++; errors++;
      $display("FAIL accept_timeout[%0d]: accepted %0d of %0d blocks", d, j, n);
    end
  endtask

  initial begin
    int acc;
    int budget;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; mode[d] = 1'b0; key[d] = '0; din[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "reset32");
    check_idle(1, "reset16");
    reset = 1'b0;
    @(negedge clk);

    // Known-answer encrypt and decrypt (all-zero key)
    issue(0, 1'b0, '0, '0, 1'b0, acc);
    push_exp(0, 64'h41EA3A0A94BAA940, acc);
    wait_idle(0);
    issue(0, 1'b1, '0, 64'h41EA3A0A94BAA940, 1'b0, acc);
    push_exp(0, 64'h0, acc);
    wait_idle(0);

    // start during RUN and during DONE is ignored; inputs change mid-run
    issue(0, 1'b0, rand128(), rand64(), 1'b1, acc);
    repeat (4) @(negedge clk);
    mode[0] = 1'b1; key[0] = rand128(); din[0] = rand64(); start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    budget = 100;
    while (done[0] !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL ignore_done_timeout: done never seen");
    end
    din[0] = rand64(); start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (rnds(0) + 4) @(negedge clk);
    chk("ignored_start_busy", {63'd0, busy[0]}, 64'd0);

    // Reset mid-run (with start asserted) aborts the block
    wait_idle(0);
    issue(0, 1'b0, rand128(), rand64(), 1'b0, acc);
    repeat (9) @(negedge clk);
    reset = 1'b1; start[0] = 1'b1; din[0] = rand64();
    @(posedge clk);
    #1;
    check_idle(0, "midrun_reset");
    @(negedge clk);
    reset = 1'b0; start[0] = 1'b0;
    repeat (rnds(0) + 6) @(negedge clk);
    chk("post_abort_busy", {63'd0, busy[0]}, 64'd0);
    chk("post_abort_data_out", dout[0], 64'd0);
    issue(0, 1'b1, rand128(), rand64(), 1'b1, acc);
    wait_idle(0);

    // 1000 encrypt/decrypt round trips per instance, start held high
    fork
      run_pairs(0, 2000);
      run_pairs(1, 2000);
    join

    budget = 200;
    while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_q32", 64'(q0.size()), 64'd0);
    chk("drain_q16", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tea_cipher_core.md
TEA_CIPHER_CORE -- requirements
Module: tea_cipher_core

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: ROUNDS, 32, number of TEA cycles per block (legal 1..64).
REQ-003 Parameter: DELTA, 32'h9E3779B9, key-schedule constant.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: start  input  1  request; sampled only in IDLE.
REQ-007 Port: mode  input  1  0 = encrypt, 1 = decrypt; sampled with start.
REQ-008 Port: key  input  128  key; k0=key[127:96], k1=[95:64], k2=[63:32], k3=[31:0]; sampled with start.
REQ-009 Port: data_in  input  64  block; v0=data_in[63:32], v1=data_in[31:0]; sampled with start.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: data_out  output  64  result {v0,v1}; valid when done=1, held until the next completion.

Function
REQ-013 The states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE with start=1 SHALL latch v0, v1, key, mode and round counter=0, then enter RUN. Sum is set to 0 for encrypt and to DELTA*ROUNDS mod 2^32 for decrypt.
REQ-015 F(x,ka,kb,s) SHALL be ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb), with logical shifts and all arithmetic mod 2^32.
REQ-016 Each RUN clock in encrypt mode SHALL perform one TEA cycle: s=sum+DELTA; v0'=v0+F(v1,k0,k1,s); v1'=v1+F(v0',k2,k3,s); sum<=s.
REQ-017 Each RUN clock in decrypt mode SHALL perform: v1'=v1-F(v0,k2,k3,sum); v0'=v0-F(v1',k0,k1,sum); sum<=sum-DELTA.
REQ-018 After the ROUNDS-th RUN clock, the block SHALL write data_out={v0,v1} and enter DONE.
REQ-019 DONE SHALL assert done for exactly one clock, then return to IDLE. done is high in the clock ROUNDS+1 after the start edge.
REQ-020 start while busy=1, including during DONE, SHALL be ignored with no effect. The earliest next accept is the first IDLE clock after DONE.
REQ-021 Changes to mode, key or data_in during RUN SHALL NOT affect the current operation.
REQ-022 Throughput SHALL be one block per ROUNDS+2 clocks with start held high.

Reset
REQ-023 reset=1 SHALL force IDLE and clear busy=0, done=0, data_out=0, counter, sum and internal v0/v1, regardless of state.
REQ-024 Reset mid-operation SHALL abort the operation with no done pulse. Reset SHALL take priority over start in the same clock.

Structure
REQ-025 Package tea_pkg SHALL hold the DELTA default, the state enum (IDLE/RUN/DONE) and the 32-bit word typedef.
REQ-026 The F function SHALL be a combinational sub-module tea_round_f, instantiated twice.
REQ-027 Counter width SHALL be $clog2(ROUNDS+1). The decrypt sum initial value SHALL be a constant computed at elaboration.

Verification
REQ-028 ROUNDS=32, encrypt, key=0, data_in=0 -> done at clock 33 after start, data_out=64'h41EA3A0A94BAA940.
REQ-029 ROUNDS=32, decrypt, key=0, data_in=64'h41EA3A0A94BAA940 -> data_out=0.
REQ-030 Random key and data, encrypt then decrypt, 1000 iterations, for ROUNDS=32 and for ROUNDS=16 -> round trip returns data_in exactly.
REQ-031 start pulsed with different data at RUN clock 5 and during DONE -> ignored; result matches the first block; single done pulse.
REQ-032 reset asserted at RUN clock 10, then a new start -> no done for the aborted block; outputs zero after reset; the new block completes correctly in ROUNDS+1 clocks.
REQ-033 start held high continuously -> done pulses every ROUNDS+2 clocks; busy low for exactly one clock between blocks.
